snn_frame_ctrl: RTL and testbench
=================================

Name: snn_frame_ctrl

Overview:
Top-level sequencer for the SNN digit classifier. It receives a 28x28 binary image as 98 packed bytes from the UART receiver and unpacks each byte into the 784x1 input-unit RAM. It then starts the SNN core, waits for its done pulse, and returns the classified digit as one ASCII byte through the UART transmitter. A one-byte holding buffer absorbs a received byte that arrives while the previous byte is still being unpacked.

Parameters:
NUM_BYTES, 98, packed bytes per image frame (8 pixels each)
ADDR_W, 10, input-RAM address width
ASCII_BASE, 8'h30, offset added to the digit for transmission

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
rx_rdy  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte; pixel i of the byte is bit i (LSB first)
ram_we  out  1  input-RAM write enable
ram_addr  out  ADDR_W  input-RAM address (pixel index 0..783)
ram_data  out  1  pixel bit to write
core_start  out  1  one-cycle start pulse to the SNN core
core_done  in  1  one-cycle done pulse from the SNN core
core_digit  in  4  classified digit, valid when core_done=1
tx_start  out  1  one-cycle pulse: transmit tx_data
tx_data  out  8  byte to transmit
tx_done  in  1  one-cycle pulse: UART transmit complete
digit_out  out  4  last classified digit; held until the next result
busy  out  1  high in every state except IDLE
overrun  out  1  sticky error flag: a received byte was dropped

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; pending buffer empty; overrun 0.
- Reset is asynchronous. Asserting rst mid-operation aborts the frame immediately: counters and state return to reset values and no further RAM writes occur.
- State machine states: IDLE, UNPACK, START, WAIT_CORE, SEND, WAIT_TX.
- IDLE:
  - rx_rdy=1 -> capture rx_data into the shift register, clear overrun, set byte counter to 0, go to UNPACK.
- UNPACK: 8 cycles. ram_we=1, ram_addr = byte_cnt*8 + bit_idx, ram_data = shreg[bit_idx], with bit_idx running 0..7.
  - Latency: rx_rdy in cycle N gives writes in cycles N+1..N+8.
  - After bit 7, the byte counter increments.
  - If the count reaches NUM_BYTES -> go to START.
  - Else, if the pending buffer is valid -> load the pending byte into the shift register, mark the buffer empty, and continue UNPACK in the next cycle with no gap.
  - Else -> wait in UNPACK with ram_we=0 until rx_rdy arrives, then capture and unpack starting the next cycle.
- rx_rdy while UNPACK is actively writing:
  - Pending buffer empty -> store the byte in the pending buffer.
  - Pending buffer full -> drop the byte and set overrun.
- rx_rdy in START, WAIT_CORE, SEND or WAIT_TX -> drop the byte and set overrun. Overrun stays set until the next frame starts from IDLE.
- rx_rdy in the same cycle that the buffer empties (last write cycle of a byte with the buffer valid) -> the incoming byte goes into the just-freed buffer and nothing is lost.
- START: core_start=1 for exactly one cycle, in the cycle after the write to address 783; then go to WAIT_CORE.
- WAIT_CORE: when core_done=1 -> register digit_out=core_digit and tx_data = ASCII_BASE + {4'h0, core_digit}, then go to SEND.
  - No timeout; the block waits indefinitely.
  - A core_done seen in any other state is ignored.
- SEND: tx_start=1 for one cycle; tx_data is held stable from SEND until tx_done. Then go to WAIT_TX.
- WAIT_TX: when tx_done=1 -> go to IDLE.
- busy=1 in every state except IDLE.
- Arithmetic: ram_addr is computed as {byte_cnt, bit_idx[2:0]}, zero-extended to ADDR_W; the maximum address is 783. The byte counter does not wrap within a frame.
- ram_addr is held at its last value whenever ram_we=0.

Test Plan:
- Reset, then 98 bytes of 8'hA5 spaced 20 cycles apart -> 784 writes. Addresses 0..7 carry data 1,0,1,0,0,1,0,1; the last write is addr 783, data 1. core_start pulses once, in the cycle after the addr-783 write.
- Three bytes 8'h01, 8'h02, 8'h03 on consecutive cycles -> the first two are written back-to-back with no gap. The third is dropped, overrun=1 and stays high, and the next frame clears it.
- Full frame, then core_done with core_digit=4'd7 -> digit_out=7, tx_data=8'h37, tx_start pulses one cycle later. tx_done returns the block to IDLE with busy=0.
- rx_rdy during WAIT_CORE -> no RAM write and overrun=1. core_done with digit 4'd0 -> tx_data=8'h30.
- Assert rst after 40 bytes (mid-UNPACK) -> all outputs 0 immediately. After release, a fresh 98-byte frame writes from address 0 and completes normally.
- core_done pulse while in IDLE -> ignored: no tx_start, digit_out unchanged.

Source files
------------

// File: rtl/snn_frame_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer for the SNN digit classifier: unpacks a packed binary image into
// the input-unit RAM, runs the core, and sends the classified digit back as ASCII.
module snn_frame_ctrl #(
  parameter int          NUM_BYTES  = 98,
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  ASCII_BASE = 8'h30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [3:0]        digit_out,
  output logic              busy,
  output logic              overrun,
  output logic [2:0]        state_dbg
);

  // Handshakes: rx_rdy, core_start, core_done, tx_start and tx_done are single-cycle
  // strobes with no back-pressure; the data beside a strobe is only valid in that cycle.

  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNPACK    = 3'd1,
    START     = 3'd2,
    WAIT_CORE = 3'd3,
    SEND      = 3'd4,
    WAIT_TX   = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       pend_data;
  logic             pend_valid;

  logic [2:0]       bit_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_bit;
  logic             frame_end;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [CNT_W-1:0] c,
                                                 input logic [2:0] b);
    return ADDR_W'({c, b});
  endfunction

  always_comb begin
    bit_nxt   = bit_idx + 3'd1;
    cnt_nxt   = byte_cnt + CNT_W'(1);
    last_bit  = (bit_idx == 3'd7);
    frame_end = (cnt_nxt == CNT_W'(NUM_BYTES));
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      overrun    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= 1'b0;
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      digit_out  <= '0;
    end else begin
      core_start <= 1'b0;
      tx_start   <= 1'b0;
      if (rx_rdy && (state inside {START, WAIT_CORE, SEND, WAIT_TX}))
        overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_rdy) begin
            shreg      <= rx_data;
            byte_cnt   <= '0;
            bit_idx    <= '0;
            pend_valid <= 1'b0;
            overrun    <= 1'b0;
            ram_we     <= 1'b1;
            ram_addr   <= '0;
            ram_data   <= rx_data[0];
            state      <= UNPACK;
          end
        end

        UNPACK: begin
          if (ram_we) begin
            if (!last_bit) begin
              bit_idx  <= bit_nxt;
              ram_addr <= pix_addr(byte_cnt, bit_nxt);
              ram_data <= shreg[bit_nxt];
              if (rx_rdy) begin
                if (!pend_valid) begin
                  pend_valid <= 1'b1;
                  pend_data  <= rx_data;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              byte_cnt <= cnt_nxt;
              bit_idx  <= '0;
              if (frame_end) begin
                // Anything still buffered belongs to no frame and is lost.
                ram_we     <= 1'b0;
                core_start <= 1'b1;
                pend_valid <= 1'b0;
                if (rx_rdy || pend_valid) overrun <= 1'b1;
                state      <= START;
              end else if (pend_valid) begin
                shreg      <= pend_data;
                ram_addr   <= pix_addr(cnt_nxt, 3'd0);
                ram_data   <= pend_data[0];
                pend_valid <= rx_rdy;
                if (rx_rdy) pend_data <= rx_data;
              end else if (rx_rdy) begin
                shreg    <= rx_data;
                ram_addr <= pix_addr(cnt_nxt, 3'd0);
                ram_data <= rx_data[0];
              end else begin
                ram_we <= 1'b0;
              end
            end
          end else if (rx_rdy) begin
            shreg    <= rx_data;
            ram_we   <= 1'b1;
            ram_addr <= pix_addr(byte_cnt, 3'd0);
            ram_data <= rx_data[0];
          end
        end

        START: state <= WAIT_CORE;

        WAIT_CORE: begin
          if (core_done) begin
            digit_out <= core_digit;
            tx_data   <= ASCII_BASE + {4'h0, core_digit};
            tx_start  <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: state <= WAIT_TX;

        WAIT_TX: begin
          if (tx_done) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_frame_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for snn_frame_ctrl: random image frames are checked against a
// pixel-stream model built from the bytes the bench sends.
module tb_snn_frame_ctrl;
  localparam int NUM_BYTES = 98;
  localparam int ADDR_W    = 10;
  localparam int NPIX      = NUM_BYTES * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              core_done = 1'b0;
  logic [3:0]        core_digit = '0;
  logic              tx_done = 1'b0;
  logic              ram_we, ram_data, core_start, tx_start, busy, overrun;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        tx_data;
  logic [3:0]        digit_out;
  logic [2:0]        state_dbg;

  snn_frame_ctrl #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W), .ASCII_BASE(8'h30)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .digit_out(digit_out), .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [ADDR_W:0] exp_q[$];
  logic [ADDR_W:0] act_q[$];
  int              wr_cyc_q[$];
  int cs_cnt = 0, cs_cyc = 0, ts_cnt = 0, ts_cyc = 0;
  int done_cyc = 0;
  logic [7:0] frame_bytes[NUM_BYTES];
  logic [3:0] last_digit = '0;
  logic [7:0] last_tx = '0;

  always @(negedge clk) begin
    if (ram_we) begin
      act_q.push_back({ram_addr, ram_data});
      wr_cyc_q.push_back(cyc);
    end
    if (core_start) begin
      cs_cnt <= cs_cnt + 1;
      cs_cyc <= cyc;
    end
    if (tx_start) begin
      ts_cnt <= ts_cnt + 1;
      ts_cyc <= cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    act_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick(1);
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // Pixel i of byte k lands at address 8k+i.
  task automatic expect_byte(input int k, input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back({ADDR_W'(k * 8 + i), b[i]});
  endtask

  task automatic send_bytes(input int first, input int last, input int gmin, input int gmax);
    for (int k = first; k <= last; k++) begin
      send_byte(frame_bytes[k]);
      expect_byte(k, frame_bytes[k]);
      if (k != last) tick($urandom_range(gmax, gmin) - 1);
    end
  endtask

  task automatic randomize_frame();
    for (int k = 0; k < NUM_BYTES; k++) frame_bytes[k] = 8'($urandom);
  endtask

  task automatic wait_core_start(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (cs_cnt > base) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic pulse_done(input logic [3:0] d);
    core_digit = d;
    core_done  = 1'b1;
    done_cyc   = cyc;
    tick(1);
    core_done  = 1'b0;
    core_digit = 4'($urandom);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic finish_quiet(input logic [3:0] d);
    tick(3);
    pulse_done(d);
    tick(4);
    pulse_tx_done();
    last_digit = d;
    last_tx    = 8'(48 + int'(d));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(2);
    checks++;
    if ({ram_we, ram_addr, ram_data, core_start, tx_start, tx_data, digit_out, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_held outputs=%h required=0",
               {ram_we, ram_addr, ram_data, core_start, tx_start, tx_data, digit_out, busy, overrun});
    end
    rst = 1'b0;
    tick(2);
    checks++;
    if ({ram_we, ram_addr, ram_data, core_start, tx_start, tx_data, digit_out, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_released outputs=%h required=0",
               {ram_we, ram_addr, ram_data, core_start, tx_start, tx_data, digit_out, overrun});
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy busy=%b required=0", busy);
    end
  endtask

  task automatic test_full_frame_a5();
    bit ok;
    int base_cs, base_ts;
    logic [7:0] pat;
    logic [ADDR_W:0] last_exp;
    pat = 8'hA5;
    last_exp = {ADDR_W'(783), 1'b1};
    clear_sb();
    for (int k = 0; k < NUM_BYTES; k++) frame_bytes[k] = pat;
    base_cs = cs_cnt;
    base_ts = ts_cnt;
    send_bytes(0, NUM_BYTES - 1, 20, 20);
    wait_core_start(base_cs, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL a5_core_start_timeout seen=0 required=1"); end
    tick(4);
    checks++;
    if (act_q.size() != NPIX) begin
      errors++; $display("FAIL a5_write_count got=%0d required=%0d", act_q.size(), NPIX);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL a5_write[%0d] got=%h required=%h", i, (i < act_q.size()) ? act_q[i] : 'x, exp_q[i]);
      end
    end
    for (int i = 0; i < 8 && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i][0] !== pat[i]) begin
        errors++; $display("FAIL a5_pixel[%0d] got=%b required=%b", i, act_q[i][0], pat[i]);
      end
    end
    if (act_q.size() > 0) begin
      checks++;
      if (act_q[act_q.size() - 1] !== last_exp) begin
        errors++; $display("FAIL a5_last_write got=%h required=%h", act_q[act_q.size() - 1], last_exp);
      end
      checks++;
      if (cs_cyc != wr_cyc_q[wr_cyc_q.size() - 1] + 1) begin
        errors++; $display("FAIL a5_core_start_cycle got=%0d required=%0d", cs_cyc, wr_cyc_q[wr_cyc_q.size() - 1] + 1);
      end
    end
    checks++;
    if (cs_cnt != base_cs + 1) begin
      errors++; $display("FAIL a5_core_start_pulses got=%0d required=1", cs_cnt - base_cs);
    end
    pulse_done(4'd7);
    checks++;
    if (digit_out !== 4'd7 || tx_data !== 8'h37) begin
      errors++; $display("FAIL result7 digit=%0d tx=%h required digit=7 tx=37", digit_out, tx_data);
    end
    tick(5);
    checks++;
    if (ts_cnt != base_ts + 1 || ts_cyc != done_cyc + 1) begin
      errors++; $display("FAIL tx_start_timing pulses=%0d cycle=%0d required 1 at %0d", ts_cnt - base_ts, ts_cyc, done_cyc + 1);
    end
    checks++;
    if (tx_data !== 8'h37 || busy !== 1'b1) begin
      errors++; $display("FAIL tx_hold tx=%h busy=%b required tx=37 busy=1", tx_data, busy);
    end
    pulse_tx_done();
    last_digit = 4'd7;
    last_tx    = 8'h37;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tx_done_idle busy=%b required=0", busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sent0, base_cs;
    logic [7:0] nb;
    clear_sb();
    randomize_frame();
    frame_bytes[0] = 8'h01;
    frame_bytes[1] = 8'h02;
    base_cs = cs_cnt;
    sent0 = cyc;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    expect_byte(0, 8'h01);
    expect_byte(1, 8'h02);
    tick(20);
    checks++;
    if (act_q.size() != 16) begin
      errors++; $display("FAIL b2b_write_count got=%0d required=16", act_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[0] != sent0 + 1 || wr_cyc_q[15] != sent0 + 16) begin
        errors++; $display("FAIL b2b_gapless first=%0d last=%0d required %0d..%0d", wr_cyc_q[0], wr_cyc_q[15], sent0 + 1, sent0 + 16);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got=%b required=1", overrun); end
    send_bytes(2, NUM_BYTES - 1, 8, 12);
    wait_core_start(base_cs, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_core_start_timeout seen=0 required=1"); end
    tick(2);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky got=%b required=1", overrun); end
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_frame_count got=%0d required=%0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_write[%0d] got=%h required=%h", i, (i < act_q.size()) ? act_q[i] : 'x, exp_q[i]);
      end
    end
    finish_quiet(4'($urandom_range(9, 0)));
    // A new frame clears the sticky flag.
    clear_sb();
    randomize_frame();
    base_cs = cs_cnt;
    nb = frame_bytes[0];
    send_byte(nb);
    expect_byte(0, nb);
    tick(1);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL next_frame_overrun got=%b required=0", overrun); end
    tick(10);
    send_bytes(1, NUM_BYTES - 1, 8, 12);
    wait_core_start(base_cs, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL next_frame_core_start_timeout seen=0 required=1"); end
    finish_quiet(4'($urandom_range(9, 0)));
  endtask

  task automatic test_rx_in_wait_core();
    bit ok;
    int base_cs, n;
    clear_sb();
    randomize_frame();
    base_cs = cs_cnt;
    send_bytes(0, NUM_BYTES - 1, 8, 12);
    wait_core_start(base_cs, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wc_core_start_timeout seen=0 required=1"); end
    tick(2);
    n = act_q.size();
    checks++;
    if (n != NPIX) begin errors++; $display("FAIL wc_write_count got=%0d required=%0d", n, NPIX); end
    send_byte(8'($urandom));
    tick(5);
    checks++;
    if (act_q.size() != n) begin
      errors++; $display("FAIL wc_no_write got=%0d required=%0d", act_q.size(), n);
    end
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL wc_overrun overrun=%b busy=%b required 1 1", overrun, busy);
    end
    pulse_done(4'd0);
    checks++;
    if (tx_data !== 8'h30 || digit_out !== 4'd0) begin
      errors++; $display("FAIL result0 tx=%h digit=%0d required tx=30 digit=0", tx_data, digit_out);
    end
    tick(2);
    pulse_tx_done();
    last_digit = 4'd0;
    last_tx    = 8'h30;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base_cs, n;
    logic [3:0] d;
    clear_sb();
    randomize_frame();
    send_bytes(0, 40, 10, 10);
    tick(3);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_data, core_start, tx_start, tx_data, digit_out, busy, overrun} !== '0) begin
      errors++;
      $display("FAIL mid_reset outputs=%h required=0",
               {ram_we, ram_addr, ram_data, core_start, tx_start, tx_data, digit_out, busy, overrun});
    end
    n = act_q.size();
    tick(3);
    rst = 1'b0;
    last_digit = '0;
    last_tx    = '0;
    tick(3);
    checks++;
    if (act_q.size() != n) begin
      errors++; $display("FAIL mid_reset_no_write got=%0d required=%0d", act_q.size(), n);
    end
    clear_sb();
    randomize_frame();
    base_cs = cs_cnt;
    send_bytes(0, NUM_BYTES - 1, 8, 12);
    wait_core_start(base_cs, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_core_start_timeout seen=0 required=1"); end
    tick(2);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL post_reset_count got=%0d required=%0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= act_q.size() || act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL post_reset_write[%0d] got=%h required=%h", i, (i < act_q.size()) ? act_q[i] : 'x, exp_q[i]);
      end
    end
    d = 4'($urandom_range(9, 1));
    finish_quiet(d);
    checks++;
    if (digit_out !== d || tx_data !== 8'(48 + int'(d)) || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset_result digit=%0d tx=%h busy=%b required digit=%0d tx=%h busy=0",
                         digit_out, tx_data, busy, d, 8'(48 + int'(d)));
    end
  endtask

  task automatic test_idle_done();
    int base_ts;
    logic [3:0] d;
    tick(3);
    base_ts = ts_cnt;
    d = last_digit + 4'd1;
    pulse_done(d);
    tick(6);
    checks++;
    if (ts_cnt != base_ts) begin
      errors++; $display("FAIL idle_done_tx_start got=%0d required=0", ts_cnt - base_ts);
    end
    checks++;
    if (digit_out !== last_digit || tx_data !== last_tx || busy !== 1'b0) begin
      errors++; $display("FAIL idle_done_hold digit=%0d tx=%h busy=%b required digit=%0d tx=%h busy=0",
                         digit_out, tx_data, busy, last_digit, last_tx);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_frame_a5();
    test_back_to_back();
    test_rx_in_wait_core();
    test_reset_mid();
    test_idle_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
